// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    KILL  = 2'd3
  } fetch_state_e;

  localparam logic [15:0] RESET_PC_DEFAULT  = 16'h0000;
  localparam logic [15:0] PC_STEP_DEFAULT   = 16'd1;
  localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0000;

  // One fetched instruction tagged with its fetch PC (IF/ID and skid buffer).
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of redirect, stall, instruction-memory and IF/ID signals around the fetch stage.
interface fetch_sequencer_if;
  import fetch_pkg::*;

  logic         pcSrc;
  logic [15:0]  branchTarget_address;
  logic         stall;
  // imem handshake: imem_req is held high with imem_addr stable until the
  // cycle imem_ready=1; imem_rdata is valid only in that same cycle.
  logic         imem_req;
  logic [15:0]  imem_addr;
  logic         imem_ready;
  logic [15:0]  imem_rdata;
  logic [15:0]  pc_address;
  logic         if_id_valid;
  logic [15:0]  if_id_instruction;
  logic [15:0]  if_id_pc;
  fetch_state_e dbg_state;

  modport master (
    input  pcSrc, branchTarget_address, stall, imem_ready, imem_rdata,
    output imem_req, imem_addr, pc_address, if_id_valid, if_id_instruction,
           if_id_pc, dbg_state
  );

  modport slave (
    output pcSrc, branchTarget_address, stall, imem_ready, imem_rdata,
    input  imem_req, imem_addr, pc_address, if_id_valid, if_id_instruction,
           if_id_pc, dbg_state
  );

endinterface

// File: rtl/fetch_sequencer_if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold; otherwise it drains to a bubble.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         flush_i,
  input  logic         hold_i,
  input  fetch_entry_t d_i,
  output logic         valid_o,
  output fetch_entry_t q_o
);

  logic         valid_q;
  fetch_entry_t entry_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q       <= 1'b0;
      entry_q.instr <= NOP_INSTR;
      entry_q.pc    <= 16'h0000;
    end else if (flush_i) begin
      valid_q       <= 1'b0;
      entry_q.instr <= NOP_INSTR;
    end else if (load_i) begin
      valid_q <= 1'b1;
      entry_q <= d_i;
    end else if (!hold_i) begin
      // Decode consumed the entry and nothing new arrived.
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = entry_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch stage: owns the PC, runs the imem request handshake and feeds IF/ID.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [15:0] PC_STEP   = PC_STEP_DEFAULT,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               inp_clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
);

  fetch_state_e state_q;
  logic [15:0]  pc_q;
  logic [15:0]  addr_q;
  fetch_entry_t skid_q;

  logic         accept;
  logic         ifid_load;
  fetch_entry_t ifid_d;
  fetch_entry_t ifid_q;
  logic         ifid_valid;

  assign accept    = (state_q == FETCH) && bus.imem_ready && !bus.pcSrc;
  assign ifid_load = (accept && !bus.stall) || ((state_q == HOLD) && !bus.stall);

  always_comb begin
    ifid_d.instr = bus.imem_rdata;
    ifid_d.pc    = pc_q;
    if (state_q == HOLD) ifid_d = skid_q;
  end

  always_ff @(posedge inp_clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      skid_q  <= '0;
    end else if (bus.pcSrc) begin
      pc_q   <= bus.branchTarget_address;
      skid_q <= '0;
      // A pending request must finish at its old address before the redirect is fetched.
      if (((state_q == FETCH) || (state_q == KILL)) && !bus.imem_ready) begin
        state_q <= KILL;
      end else begin
        state_q <= FETCH;
        addr_q  <= bus.branchTarget_address;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          addr_q  <= pc_q;
        end
        FETCH: begin
          if (bus.imem_ready) begin
            pc_q   <= pc_q + PC_STEP;
            addr_q <= pc_q + PC_STEP;
            if (bus.stall) begin
              skid_q.instr <= bus.imem_rdata;
              skid_q.pc    <= pc_q;
              state_q      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!bus.stall) state_q <= FETCH;
        end
        KILL: begin
          if (bus.imem_ready) begin
            state_q <= FETCH;
            addr_q  <= pc_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk_i   (inp_clk),
    .rst_i   (rst),
    .load_i  (ifid_load),
    .flush_i (bus.pcSrc),
    .hold_i  (bus.stall),
    .d_i     (ifid_d),
    .valid_o (ifid_valid),
    .q_o     (ifid_q)
  );

  assign bus.imem_req          = (state_q == FETCH) || (state_q == KILL);
  assign bus.imem_addr         = addr_q;
  assign bus.pc_address        = pc_q;
  assign bus.if_id_valid       = ifid_valid;
  assign bus.if_id_instruction = ifid_q.instr;
  assign bus.if_id_pc          = ifid_q.pc;
  assign bus.dbg_state         = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an expected-load queue for IF/ID contents.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic clk;
  logic rst;
  fetch_sequencer_if bus();

  fetch_sequencer dut (
    .inp_clk (clk),
    .rst     (rst),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_pc;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a ^ 16'h3C5A) + 16'h0101;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic p, input logic [15:0] t, input logic s,
                       input logic r, input logic [15:0] d);
    bus.pcSrc                = p;
    bus.branchTarget_address = t;
    bus.stall                = s;
    bus.imem_ready           = r;
    bus.imem_rdata           = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_load(input string tag);
    logic [31:0] e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s: observed an IF/ID load expected an empty queue", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(bus.if_id_valid), 32'd1);
      chk({tag, "_entry"}, {bus.if_id_instruction, bus.if_id_pc}, e);
    end
  endtask

  // One fetch answered in its request cycle, with no stall and no redirect.
  task automatic accept_one(input string tag);
    chk({tag, "_addr"}, 32'(bus.imem_addr), 32'(exp_pc));
    chk({tag, "_req"}, 32'(bus.imem_req), 32'd1);
    drive(1'b0, 16'h0, 1'b0, 1'b1, mem_word(exp_pc));
    exp_q.push_back({mem_word(exp_pc), exp_pc});
    tick();
    check_load(tag);
    exp_pc = exp_pc + 16'd1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(bus.imem_req), 32'd0);
    chk({tag, "_pc"}, 32'(bus.pc_address), 32'h0000);
    chk({tag, "_valid"}, 32'(bus.if_id_valid), 32'd0);
    chk({tag, "_instr"}, 32'(bus.if_id_instruction), 32'h0000);
    chk({tag, "_ifid_pc"}, 32'(bus.if_id_pc), 32'h0000);
    chk({tag, "_state"}, 32'(bus.dbg_state), 32'(IDLE));
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    tick();
    tick();
    check_reset_outputs("reset");

    // Reset release with a single-cycle memory.
    rst = 1'b0;
    tick();
    chk("release_state", 32'(bus.dbg_state), 32'(FETCH));
    exp_pc = 16'h0000;
    for (int i = 0; i < 5; i++) accept_one("stream");

    // Three-cycle latency at 0x0005: address must stay put while pending.
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'hBEEF);
      tick();
      chk("lat_addr", 32'(bus.imem_addr), 32'h0005);
      chk("lat_req", 32'(bus.imem_req), 32'd1);
      chk("lat_pc", 32'(bus.pc_address), 32'h0005);
    end
    accept_one("lat_resp");

    // Redirect in the same cycle as a response: data dropped, target fetched next.
    drive(1'b1, 16'h000F, 1'b0, 1'b1, mem_word(16'h0006));
    tick();
    chk("redir_rdy_valid", 32'(bus.if_id_valid), 32'd0);
    chk("redir_rdy_instr", 32'(bus.if_id_instruction), 32'h0000);
    chk("redir_rdy_addr", 32'(bus.imem_addr), 32'h000F);
    chk("redir_rdy_state", 32'(bus.dbg_state), 32'(FETCH));
    exp_pc = 16'h000F;
    accept_one("pre_stall");

    // Response at 0x0010 while decode stalls for four cycles.
    drive(1'b0, 16'h0, 1'b1, 1'b1, mem_word(16'h0010));
    tick();
    chk("stall_state", 32'(bus.dbg_state), 32'(HOLD));
    chk("stall_req", 32'(bus.imem_req), 32'd0);
    chk("stall_pc", 32'(bus.pc_address), 32'h0011);
    chk("stall_keep", {bus.if_id_instruction, bus.if_id_pc}, {mem_word(16'h000F), 16'h000F});
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      tick();
      chk("hold_state", 32'(bus.dbg_state), 32'(HOLD));
      chk("hold_keep", {bus.if_id_instruction, bus.if_id_pc}, {mem_word(16'h000F), 16'h000F});
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    exp_q.push_back({mem_word(16'h0010), 16'h0010});
    tick();
    check_load("skid_release");
    chk("skid_state", 32'(bus.dbg_state), 32'(FETCH));
    chk("skid_next_addr", 32'(bus.imem_addr), 32'h0011);
    exp_pc = 16'h0011;
    accept_one("post_skid");

    drive(1'b1, 16'h001F, 1'b0, 1'b1, mem_word(16'h0012));
    tick();
    chk("redir2_addr", 32'(bus.imem_addr), 32'h001F);
    exp_pc = 16'h001F;
    accept_one("pre_kill");

    // Redirect to 0x0100 while the 0x0020 request is pending two cycles.
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    tick();
    chk("pend_addr", 32'(bus.imem_addr), 32'h0020);
    drive(1'b1, 16'h0100, 1'b0, 1'b0, 16'h0);
    tick();
    chk("kill_state", 32'(bus.dbg_state), 32'(KILL));
    chk("kill_valid", 32'(bus.if_id_valid), 32'd0);
    chk("kill_instr", 32'(bus.if_id_instruction), 32'h0000);
    chk("kill_req", 32'(bus.imem_req), 32'd1);
    chk("kill_addr", 32'(bus.imem_addr), 32'h0020);
    chk("kill_pc", 32'(bus.pc_address), 32'h0100);
    drive(1'b0, 16'h0, 1'b0, 1'b1, mem_word(16'h0020));
    tick();
    chk("kill_done_state", 32'(bus.dbg_state), 32'(FETCH));
    chk("kill_drop_valid", 32'(bus.if_id_valid), 32'd0);
    chk("kill_drop_instr", 32'(bus.if_id_instruction), 32'h0000);
    chk("kill_next_addr", 32'(bus.imem_addr), 32'h0100);
    exp_pc = 16'h0100;
    accept_one("post_kill");

    // Redirect together with stall while IF/ID is live.
    drive(1'b1, 16'hFFFE, 1'b1, 1'b0, 16'h0);
    tick();
    chk("flush_stall_valid", 32'(bus.if_id_valid), 32'd0);
    chk("flush_stall_pc", 32'(bus.pc_address), 32'hFFFE);
    chk("flush_stall_state", 32'(bus.dbg_state), 32'(KILL));
    drive(1'b0, 16'h0, 1'b0, 1'b1, mem_word(16'h0101));
    tick();
    chk("flush_stall_addr", 32'(bus.imem_addr), 32'hFFFE);
    exp_pc = 16'hFFFE;

    // PC wrap at 0xFFFF.
    accept_one("wrap_a");
    accept_one("wrap_b");
    chk("wrap_pc", 32'(bus.pc_address), 32'h0000);
    chk("wrap_ifid_pc", 32'(bus.if_id_pc), 32'h0000FFFF);

    // Reset asserted while a request is outstanding.
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("mid_reset");

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
